// File: rtl/amo_unit.sv
// Atomic memory engine for LR.W / SC.W / AMO*.W: drives the data-memory req/ack port,
// owns the single-entry reservation and stalls the pipeline until the result is ready.
module amo_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_lr,
   input  logic            is_sc,
   input  logic            is_amo,
   input  logic [4:0]      amo_funct5,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            trap_flush,
   input  logic            snoop_we,
   input  logic [XLEN-1:0] snoop_addr,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            fault,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t state, state_next;

   logic            op_lr, op_sc, op_amo;
   logic [4:0]      op_funct5;
   logic [XLEN-3:0] op_word;
   logic [XLEN-1:0] op_rs2;
   logic [XLEN-1:0] old_q;
   logic            resv_valid;
   logic [XLEN-3:0] resv_word;

   logic accept, reject, resv_hit, rd_ack, wr_ack;
   logic lr_done, amo_hit, snoop_hit, resv_kill;

   function automatic logic funct5_legal(input logic [4:0] f);
      case (f)
         5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
         5'b10000, 5'b10100, 5'b11000, 5'b11100: funct5_legal = 1'b1;
         default:                                funct5_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] amo_alu(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic [4:0]      f);
      case (f)
         5'b00001: amo_alu = b;
         5'b00000: amo_alu = a + b;
         5'b00100: amo_alu = a ^ b;
         5'b01100: amo_alu = a & b;
         5'b01000: amo_alu = a | b;
         5'b10000: amo_alu = ($signed(a) < $signed(b)) ? a : b;
         5'b10100: amo_alu = ($signed(a) > $signed(b)) ? a : b;
         5'b11000: amo_alu = (a < b) ? a : b;
         5'b11100: amo_alu = (a > b) ? a : b;
         default:  amo_alu = a;
      endcase
   endfunction

   // A request with no atomic class flagged is treated like an illegal encoding.
   always_comb begin
      accept   = (state == IDLE) && start;
      reject   = (addr[1:0] != 2'b00) ||
                 (is_amo && !funct5_legal(amo_funct5)) ||
                 !(is_lr || is_sc || is_amo);
      resv_hit = resv_valid && (resv_word == addr[XLEN-1:2]);
      rd_ack   = (state == READ) && mem_req && mem_ack;
      wr_ack   = (state == WRITE) && mem_req && mem_ack;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (reject)                state_next = DONE;
               else if (is_lr || is_amo)  state_next = READ;
               else if (resv_hit)         state_next = WRITE;
               else                       state_next = DONE;
            end
         end
         READ:    if (mem_ack) state_next = op_lr ? DONE : WRITE;
         WRITE:   if (mem_ack) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == READ) || (state == WRITE) || ((state == IDLE) && start);
      done = (state == DONE);
   end

   // Memory outputs only move at accept or on an ack edge, so they stay frozen across wait states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         result    <= '0;
         fault     <= 1'b0;
         old_q     <= '0;
         op_lr     <= 1'b0;
         op_sc     <= 1'b0;
         op_amo    <= 1'b0;
         op_funct5 <= '0;
         op_word   <= '0;
         op_rs2    <= '0;
      end else begin
         mem_req <= (state_next == READ) || (state_next == WRITE);
         mem_we  <= (state_next == WRITE);
         if (accept) begin
            op_lr     <= is_lr;
            op_sc     <= is_sc;
            op_amo    <= is_amo;
            op_funct5 <= amo_funct5;
            op_word   <= addr[XLEN-1:2];
            op_rs2    <= rs2_data;
            mem_addr  <= {addr[XLEN-1:2], 2'b00};
            if (is_sc) mem_wdata <= rs2_data;
            if (reject) begin
               result <= '0;
               fault  <= 1'b1;
            end else if (is_sc && !resv_hit) begin
               result <= {{(XLEN-1){1'b0}}, 1'b1};
               fault  <= 1'b0;
            end
         end
         if (rd_ack) begin
            old_q <= mem_rdata;
            if (op_lr) begin
               result <= mem_rdata;
               fault  <= 1'b0;
            end else begin
               mem_wdata <= amo_alu(mem_rdata, op_rs2, op_funct5);
            end
         end
         if (wr_ack) begin
            result <= op_sc ? '0 : old_q;
            fault  <= 1'b0;
         end
      end
   end

   // Any invalidation on the same edge as an LR completion beats setting the reservation.
   always_comb begin
      lr_done   = rd_ack && op_lr;
      amo_hit   = wr_ack && op_amo && resv_valid && (resv_word == op_word);
      snoop_hit = snoop_we && (snoop_addr[XLEN-1:2] == (lr_done ? op_word : resv_word));
      resv_kill = trap_flush || (accept && is_sc) || snoop_hit || amo_hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resv_valid <= 1'b0;
         resv_word  <= '0;
      end else if (resv_kill) begin
         resv_valid <= 1'b0;
      end else if (lr_done) begin
         resv_valid <= 1'b1;
         resv_word  <= op_word;
      end
   end

endmodule

// File: doc/amo_unit.md
# amo_unit

Multi-cycle atomic memory engine for the A extension. It sits in the memory stage directly downstream of instruction decode and consumes the decoder's `is_lr`/`is_sc`/`is_amo`/`amo_funct5` flags together with the rs1 address and rs2 data. It performs LR.W, SC.W and AMO*.W against the data-memory port using a req/ack handshake, and owns the single-entry reservation. It stalls the pipeline via `busy` until the result is ready.

## Interface
- `XLEN`, 32: datapath and address width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request valid; accepted only in IDLE.
- `is_lr`, `is_sc`, `is_amo`  in  1 each  decoded atomic class; exactly one is high with `start`.
- `amo_funct5`  in  5  instruction[31:27].
- `addr`  in  XLEN  effective address (rs1).
- `rs2_data`  in  XLEN  store/operand value.
- `trap_flush`  in  1  trap or MRET taken; clears reservation.
- `snoop_we`, `snoop_addr`  in  1, XLEN  ordinary store commit; invalidates a matching reservation.
- `busy`  out  1  stall request to pipeline.
- `done`  out  1  one-cycle completion pulse; `result` valid.
- `result`  out  XLEN  value for rd.
- `fault`  out  1  with `done`: misaligned address or illegal funct5.
- `mem_req`, `mem_we`  out  1  memory request and write enable.
- `mem_addr`, `mem_wdata`  out  XLEN  word address and write data.
- `mem_rdata`  in  XLEN  read data, valid with `mem_ack`.
- `mem_ack`  in  1  request completes on an edge where `mem_req && mem_ack`.

## Operation
- States: IDLE, READ, WRITE, DONE. At accept, `addr`, `rs2_data`, class and funct5 are latched; later input changes are ignored.
- `start` outside IDLE is ignored. DONE always returns to IDLE the next cycle.
- Decision at accept, in priority order:
  - Misaligned (`addr[1:0]!=0`): go to DONE with `fault=1`, `result=0`, no memory access. Reservation unchanged unless the op is SC, which clears it.
  - Illegal funct5 on AMO: same as misaligned.
  - LR: go to READ. On ack, `result=mem_rdata`, reservation `{valid=1, addr[31:2]}`, go to DONE.
  - SC: if reservation valid and `addr[31:2]` matches, go to WRITE with `result=0`; otherwise go to DONE with `result=1` and no access. Reservation is cleared in both cases.
  - AMO: go to READ, capture old value, then go to WRITE with `mem_wdata=f(old, rs2)`. `result=old`.
- AMO funct5 encodings:
  - 00001 SWAP (rs2)
  - 00000 ADD (32-bit wrap)
  - 00100 XOR
  - 01100 AND
  - 01000 OR
  - 10000 MIN (signed)
  - 10100 MAX (signed)
  - 11000 MINU
  - 11100 MAXU
  - Any other value is illegal.
- `mem_addr = {addr[31:2],2'b00}`.
- `mem_we=1` only in WRITE. `mem_req=1` in READ and WRITE.
- Reservation invalidation:
  - `trap_flush`.
  - `snoop_we` with a word-address match, in any state.
  - Own AMO write to the reserved word.
- A snoop match on the same edge an LR completes leaves the reservation invalid. Invalidation wins.
- `busy = (state==READ || state==WRITE) || (state==IDLE && start)`. It is low in DONE, so the pipeline advances on the `done` cycle.

## Timing
- Reset values: state IDLE, reservation invalid, `done=0`, `result=0`, `fault=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`. `busy` follows `start` combinationally.
- Asynchronous reset mid-operation drops `mem_req` immediately. Any in-flight access is abandoned and no `done` is produced.
- `mem_addr`, `mem_wdata` and `mem_we` are registered. They are held stable while `mem_req=1 && !mem_ack`.
- Latency from accept edge to `done`, with ack in the first request cycle:
  - LR: 2 cycles.
  - AMO: 3 cycles.
  - SC success: 2 cycles.
  - SC fail, misaligned, illegal: 1 cycle.
- Each wait-state cycle on ack adds one cycle.
- `result` and `fault` are registered. They hold their value after `done` until the next completion.

## Test plan
- LR at 0x100 with memory 0xDEADBEEF, zero-wait ack: `done` 2 cycles after accept, `result=0xDEADBEEF`. Then SC 0x100 with rs2=0x5: one write of 0x5, `result=0`.
- LR 0x100, then `snoop_we` at 0x102, then SC 0x100: no memory write, `result=1`, `done` 1 cycle after accept.
- AMOADD at 0x200 with memory 0x7FFFFFFF, rs2=1: write 0x80000000, `result=0x7FFFFFFF`. AMOMIN with mem=0xFFFFFFFF, rs2=1: write 0xFFFFFFFF. AMOMINU with the same operands: write 1.
- AMOSWAP with `mem_ack` delayed 3 cycles on both phases: address and data stable throughout, `busy` high for 8 cycles, `done` at cycle 9.
- AMO at 0x201: `fault=1`, `result=0`, no `mem_req`. funct5=00010 routed as AMO: `fault=1`.
- Assert `rst` during WRITE: `mem_req` falls the same cycle, no `done`. A following SC returns `result=1`.
